// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver: 2-flop synchronized input, mid-bit sampling, one-cycle valid/frame_err pulses.
// A stop-bit error forces a full idle bit period on the line before the next start bit is accepted.
module uart_byte_receiver #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    // state     | meaning
    // WAIT_IDLE | need CLKS_PER_BIT consecutive high samples before trusting the line
    // IDLE      | line idle, waiting for a falling edge
    // START     | counting to mid start bit to confirm it
    // DATA      | sampling 8 data bits at mid-bit
    // STOP      | sampling the stop bit
    localparam logic [2:0] WAIT_IDLE = 3'd0;
    localparam logic [2:0] IDLE      = 3'd1;
    localparam logic [2:0] START     = 3'd2;
    localparam logic [2:0] DATA      = 3'd3;
    localparam logic [2:0] STOP      = 3'd4;

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta_q, rx_meta_d;
    logic             rx_s_q, rx_s_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;

    always_comb begin
        rx_meta_d   = rx_i;
        rx_s_d      = rx_meta_q;
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            WAIT_IDLE: begin
                if (!rx_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // Leaving at mid stop bit lets a back-to-back start bit be caught.
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = WAIT_IDLE;
            end
        endcase

        busy_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= WAIT_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Scoreboard bench for uart_byte_receiver at 16 clocks per bit.
// Stimulus pushes expected frames; a negedge monitor pops and checks each valid/frame_err pulse.
module tb_uart_byte_receiver;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       rx_line;
    logic       tx_line;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    always #10 clk = ~clk;

    uart_byte_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_i      (rx_line),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    assign rx_line = loop_en ? tx_line : rx_drv;

    typedef struct {
        bit         err;
        logic [7:0] d;
        string      name;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         valid_cyc_q[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         fall_cyc = 0;
    bit         chk_lat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Loopback transmitter: 1 start, 8 data LSB first, 1 stop, same bit period.
    logic [7:0] tx_q[$];
    logic       tx_act = 1'b0;
    logic [9:0] tx_sh = 10'h3FF;
    int         tx_cnt = 0;
    int         tx_bit = 0;

    always @(posedge clk) begin
        if (!tx_act) begin
            if (tx_q.size() > 0) begin
                tx_sh  <= {1'b1, tx_q.pop_front(), 1'b0};
                tx_act <= 1'b1;
                tx_cnt <= 0;
                tx_bit <= 0;
            end
        end else if (tx_cnt == CPB - 1) begin
            tx_cnt <= 0;
            tx_sh  <= {1'b1, tx_sh[9:1]};
            if (tx_bit == 9) tx_act <= 1'b0;
            else tx_bit <= tx_bit + 1;
        end else begin
            tx_cnt <= tx_cnt + 1;
        end
    end

    assign tx_line = tx_act ? tx_sh[0] : 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (valid || frame_err)) begin
            check("pulse_exclusive", {31'b0, valid & frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b data=%0h, expected no pulse",
                         valid, frame_err, data);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_frame_err"}, {31'b0, frame_err}, {31'b0, e.err});
                check({e.name, "_data"}, {24'b0, data}, {24'b0, e.d});
                if (valid) begin
                    valid_cyc_q.push_back(cyc);
                    if (chk_lat) begin
                        chk_lat = 1'b0;
                        check("t1_latency_le_156", {31'b0, (cyc - fall_cyc) <= 156}, 32'd1);
                    end
                end
            end
        end
    end

    task automatic push(input bit err, input logic [7:0] d, input string name);
        exp_t x;
        x.err  = err;
        x.d    = d;
        x.name = name;
        exp_q.push_back(x);
    endtask

    task automatic hold(input logic v, input int n);
        rx_drv = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        fall_cyc = cyc;
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(stop, CPB);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_all_pulses_seen"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int diff;

        reset = 1'b1;
        rx_drv = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", {24'b0, data}, 32'h00);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_frame_err", {31'b0, frame_err}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;

        // Single frame 8'hAA
        hold(1'b1, 20);
        check("t1_busy_before", {31'b0, busy}, 32'd0);
        chk_lat = 1'b1;
        push(1'b0, 8'hAA, "t1");
        fork
            send(8'hAA, 1'b1);
            begin
                repeat (80) @(negedge clk);
                check("t1_busy_mid", {31'b0, busy}, 32'd1);
            end
        join
        hold(1'b1, 4);
        check("t1_busy_after", {31'b0, busy}, 32'd0);
        wait_drain("t1", 200);

        // Back-to-back 8'h00, 8'hFF
        valid_cyc_q.delete();
        push(1'b0, 8'h00, "t2a");
        push(1'b0, 8'hFF, "t2b");
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        hold(1'b1, 4);
        wait_drain("t2", 200);
        check("t2_valid_count", valid_cyc_q.size(), 32'd2);
        diff = (valid_cyc_q.size() >= 2) ? (valid_cyc_q[1] - valid_cyc_q[0]) : 0;
        n_tests++;
        if (diff < 159 || diff > 161) begin
            n_fail++;
            $display("FAIL t2_spacing: got %0d cycles, expected 160 +/-1", diff);
        end

        // 4-cycle glitch, then 7-cycle short start bit
        hold(1'b0, 4);
        hold(1'b1, 1);
        check("t3_busy_glitch", {31'b0, busy}, 32'd1);
        hold(1'b1, 7);
        check("t3_busy_released", {31'b0, busy}, 32'd0);
        check("t3_data_kept", {24'b0, data}, 32'hFF);
        hold(1'b1, 10);
        hold(1'b0, 7);
        hold(1'b1, 200);
        check("t3_busy_short", {31'b0, busy}, 32'd0);
        check("t3_data_short", {24'b0, data}, 32'hFF);

        // Framing error and recovery
        push(1'b0, 8'h3C, "t4a");
        send(8'h3C, 1'b1);
        push(1'b1, 8'h3C, "t4err");
        send(8'hC3, 1'b0);
        hold(1'b0, 40);
        hold(1'b1, 6);
        hold(1'b0, 1);
        hold(1'b1, 16);
        push(1'b0, 8'h81, "t4b");
        send(8'h81, 1'b1);
        hold(1'b1, 4);
        wait_drain("t4", 200);
        check("t4_data_final", {24'b0, data}, 32'h81);

        // Reset during bit 4 of an 8'hF0 frame
        hold(1'b0, CPB);
        hold(1'b0, 4 * CPB);
        hold(1'b1, 8);
        reset = 1'b1;
        rx_drv = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_rst_valid", {31'b0, valid}, 32'd0);
        check("t5_rst_frame_err", {31'b0, frame_err}, 32'd0);
        check("t5_rst_busy", {31'b0, busy}, 32'd0);
        check("t5_rst_data", {24'b0, data}, 32'h00);
        reset = 1'b0;
        hold(1'b1, 16);
        push(1'b0, 8'h5A, "t5");
        send(8'h5A, 1'b1);
        hold(1'b1, 4);
        wait_drain("t5", 200);
        check("t5_data_final", {24'b0, data}, 32'h5A);

        // Loopback transmitter
        loop_en = 1'b1;
        push(1'b0, 8'hAA, "t6a");
        push(1'b0, 8'h55, "t6b");
        push(1'b0, 8'h01, "t6c");
        tx_q.push_back(8'hAA);
        tx_q.push_back(8'h55);
        tx_q.push_back(8'h01);
        wait_drain("t6", 700);
        repeat (40) @(negedge clk);
        check("t6_data_final", {24'b0, data}, 32'h01);
        check("end_queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_byte_receiver.md
UART_BYTE_RECEIVER -- requirements
Module: uart_byte_receiver

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 434, clk cycles per bit (115200 baud at 50 MHz); legal range 8..65535.
REQ-002 Port: clk  input  1  system clock, all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: rx_i  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 Port: data  output  8  last correctly framed byte.
REQ-006 Port: valid  output  1  one-cycle pulse, data updated this cycle.
REQ-007 Port: frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-008 Port: busy  output  1  high while a frame is being received.

Function
REQ-009 rx_i SHALL pass through a 2-flop synchronizer; the internal rx_s is the second flop, and all decisions SHALL use rx_s only.
REQ-010 FSM states SHALL be WAIT_IDLE, IDLE, START, DATA, STOP.
REQ-011 A bit-period counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL clear on every state transition.
REQ-012 WAIT_IDLE: the counter SHALL count consecutive rx_s==1 cycles and restart on rx_s==0; reaching CLKS_PER_BIT SHALL move the FSM to IDLE.
REQ-013 IDLE: rx_s==0 SHALL move the FSM to START on the next edge.
REQ-014 START: at counter==CLKS_PER_BIT/2-1 (integer division), rx_s SHALL be sampled; 0 moves to DATA, 1 (glitch) returns to IDLE with no output pulse.
REQ-015 DATA: at each counter==CLKS_PER_BIT-1, rx_s SHALL shift into an 8-bit shift register MSB-side (shift right), giving LSB-first assembly; a 3-bit bit index SHALL increment.
REQ-016 After the 8th data sample, the FSM SHALL move to STOP.
REQ-017 STOP: at counter==CLKS_PER_BIT-1, rx_s SHALL be sampled.
REQ-018 If the stop sample is 1, the shift register SHALL load into data, valid SHALL pulse for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-019 If the stop sample is 0, frame_err SHALL pulse for exactly one cycle, data SHALL remain unchanged, valid SHALL stay 0, and the FSM SHALL go to WAIT_IDLE.
REQ-020 valid and frame_err SHALL never be high in the same cycle.
REQ-021 busy SHALL equal 1 in START, DATA and STOP, and 0 in WAIT_IDLE and IDLE (registered, state-decoded).
REQ-022 data SHALL hold its value between valid pulses.
REQ-023 Latency: valid SHALL rise no later than 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 2 cycles after the rx_i falling edge.
REQ-024 Back-to-back frames, where the next start bit begins immediately after the stop bit, SHALL be received without loss, since IDLE is re-entered mid-stop-bit.
REQ-025 A start bit shorter than CLKS_PER_BIT/2 cycles SHALL be rejected.

Reset
REQ-026 While reset is high, on each rising clk: state SHALL be WAIT_IDLE, synchronizer flops 1, counter/bit index/shift register 0, data 8'h00, valid 0, frame_err 0, busy 0.
REQ-027 Reset asserted mid-frame SHALL discard the partial byte with no valid or frame_err pulse.
REQ-028 After reset deasserts, no start bit SHALL be accepted until rx_s has been high CLKS_PER_BIT consecutive cycles.

Verification (bench CLKS_PER_BIT=16, clk period 20)
REQ-029 Reset, line idle 20 cycles, send 8'hAA -> exactly one valid pulse, data=8'hAA, frame_err never high, busy high only during the frame.
REQ-030 Back-to-back 8'h00 then 8'hFF, no idle gap -> two valid pulses 160 cycles apart ±1, data 8'h00 then 8'hFF.
REQ-031 rx_i low for 4 cycles then high -> busy pulses high, then returns to 0 by mid-start sample; no valid, no frame_err, data unchanged.
REQ-032 After 8'h3C received, send 8'hC3 with stop bit 0 and line low 40 more cycles, then 8'h81 after 16 high cycles -> one frame_err pulse, data stays 8'h3C; a falling edge within those 16 cycles is ignored; then valid with data=8'h81.
REQ-033 Reset pulsed during bit 4 of a frame, then line idle 16 cycles, send 8'h5A -> during reset all outputs 0; no pulse for the aborted frame; valid with data=8'h5A.
REQ-034 Loopback from the team uart_transmitter (same clk, matching baud) sending 8'hAA, 8'h55, 8'h01 -> three valid pulses with matching data in order.
